load_access_ctrl: RTL
=====================

Name: load_access_ctrl

Overview:
Sequences one RISC-V integer load at a time from decode through data memory to register writeback.
- Accepts decoded load fields (rs1 value, imm, rd, load_control) with a valid/ready handshake.
- Forms the effective address, issues a word-aligned request on the data-memory port, and waits for the response.
- Extracts and sign/zero-extends the byte, halfword or word, then presents a one-cycle writeback.
- Sits between the load decoder and the register file; drives the pipeline stall via busy.

Parameters:
XLEN, 32, data/address width; only 32 supported.
ZERO_RD_SUPPRESS, 1, when 1 a load with rd==0 completes the memory access but keeps wb_valid low.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  decoded load present
ld_ready  out  1  controller can accept a load (state IDLE)
rs1_val  in  32  base register value
imm  in  12  signed offset
rd  in  5  destination register
load_control  in  3  LB/LH/LW/LBU/LHU code
flush  in  1  kill the in-flight load
mem_req  out  1  memory read request
mem_addr  out  32  word-aligned address {ea[31:2],2'b00}
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word
wb_valid  out  1  writeback strobe, one cycle
wb_rd  out  5  writeback register
wb_data  out  32  extended load result
busy  out  1  state != IDLE
misalign_exc  out  1  misaligned-load exception pulse (macro only)
exc_addr  out  32  faulting effective address (macro only)

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0 except ld_ready=1. Captured ea, rd and control are cleared.
- Effective address: ea = rs1_val + sign-extended imm, modulo 2^32. It is registered at accept together with rd and load_control.
- IDLE:
  - ld_ready=1.
  - ld_valid → capture the load, go to REQ.
  - flush in IDLE is ignored.
- REQ:
  - mem_req=1 and mem_addr held stable until mem_gnt.
  - mem_gnt → WAIT.
  - flush without mem_gnt → IDLE, no writeback.
  - flush together with mem_gnt → DRAIN.
- WAIT:
  - mem_rvalid → latch the extracted data, go to WB.
  - flush without mem_rvalid → DRAIN.
  - flush together with mem_rvalid → IDLE, response discarded.
  - mem_rvalid is ignored in REQ. Memory returns rvalid at least one cycle after gnt.
- DRAIN: wait for mem_rvalid, discard it, go to IDLE; wb_valid stays 0.
- WB:
  - wb_valid=1 for exactly one cycle, with wb_rd and wb_data; then IDLE.
  - flush in WB is ignored; the writeback has already committed.
- Minimum latency: accept in cycle N, gnt in N+1, rvalid in N+2, wb_valid in N+3. A back-to-back load is accepted in N+4.
- Extraction by lane:
  - Byte lane = ea[1:0].
  - Halfword lane = ea[1] (ea[0] ignored).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Reserved load_control codes (3, 6, 7) behave as LB.
- Misaligned (LH/LHU with ea[0]=1, LW with ea[1:0]!=0) without the macro: the access proceeds and the low address bits are dropped as above.

Optional Feature:
LOAD_MISALIGN_TRAP_EN
- Defined:
  - A misaligned load accepted in IDLE goes to state EXC and issues no mem_req.
  - EXC asserts misalign_exc=1 and exc_addr=ea for one cycle, then IDLE; no writeback.
  - flush during EXC does not suppress the pulse.
- Undefined: no EXC state. misalign_exc and exc_addr are tied to 0; misaligned accesses follow the forced-alignment rule.

Decomposition:
- Package riscv_load_pkg holds:
  - load_ctrl_e: LB=3'd0, LH=3'd1, LW=3'd2, LBU=3'd4, LHU=3'd5 (funct3 values).
  - state enum: IDLE, REQ, WAIT, DRAIN, WB, EXC.
- Sub-module load_data_align (combinational): inputs mem_rdata, ea[1:0], load_control; output extended wb_data.

Test Plan:
- LB: rs1=0x1000, imm=0x003, mem_rdata=0x80FF_1234 → mem_addr=0x1000, wb_data=0xFFFF_FF80, wb_valid exactly 3 cycles after accept with immediate gnt/rvalid.
- LHU: rs1=0x2000, imm=0xFFE (-2) → ea=0x1FFE, mem_addr=0x1FFC; mem_rdata=0x8001_0000 → wb_data=0x0000_8001.
- Stalled memory: gnt delayed 4 cycles, rvalid 3 more → mem_addr stable, busy=1 throughout, ld_ready=0, exactly one wb_valid.
- flush in WAIT before rvalid → DRAIN; the later rvalid is discarded; wb_valid never asserts; next load is accepted after DRAIN.
- rd=0, LW → memory request issued, wb_valid stays 0 (ZERO_RD_SUPPRESS=1). rst_n asserted mid-WAIT → immediate IDLE with ld_ready=1.
- LW at ea=0x1002 with LOAD_MISALIGN_TRAP_EN → no mem_req, misalign_exc=1 for one cycle with exc_addr=0x1002. Without the macro → mem_addr=0x1000, full word written back.

Source files
------------

// File: rtl/riscv_load_pkg.sv
// rtl/riscv_load_pkg.sv - shared types and helpers for the load access controller
package riscv_load_pkg;

  // funct3 encodings of the integer loads
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } load_ctrl_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4,
    EXC   = 3'd5
  } state_e;

  // Halfwords need ea[0]==0, words need ea[1:0]==0; bytes never misalign.
  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] ea_lo);
    logic mis;
    mis = 1'b0;
    case (ctrl)
      LH, LHU: mis = ea_lo[0];
      LW:      mis = |ea_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_data_align.sv
// rtl/load_data_align.sv - lane select and sign/zero extension of a loaded word
module load_data_align
  import riscv_load_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  ea_lo,
  input  logic [2:0]  load_control,
  output logic [31:0] wb_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to the load type; reserved codes act as LB.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (ea_lo)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = ea_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (load_control)
      LH:      wb_data = {{16{half_sel[15]}}, half_sel};
      LW:      wb_data = mem_rdata;
      LBU:     wb_data = {24'd0, byte_sel};
      LHU:     wb_data = {16'd0, half_sel};
      default: wb_data = {{24{byte_sel[7]}}, byte_sel};
    endcase
  end

endmodule

// File: rtl/load_access_ctrl.sv
// rtl/load_access_ctrl.sv - single-outstanding load sequencer, optional trap via LOAD_MISALIGN_TRAP_EN
module load_access_ctrl
  import riscv_load_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [11:0]     imm,
  input  logic [4:0]      rd,
  input  logic [2:0]      load_control,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            misalign_exc,
  output logic [XLEN-1:0] exc_addr
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ea_q, ea_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] accept_ea;
  logic [XLEN-1:0] align_data;

  assign accept_ea = rs1_val + {{(XLEN-12){imm[11]}}, imm};

  load_data_align u_align (
    .mem_rdata    (mem_rdata),
    .ea_lo        (ea_q[1:0]),
    .load_control (ctrl_q),
    .wb_data      (align_data)
  );

  // State and captured load fields; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ea_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ea_q      <= ea_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Capture the decoded load at accept and the extended data on the response.
  always_comb begin
    ea_d      = ea_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    wb_data_d = wb_data_q;
    if (state_q == IDLE && ld_valid) begin
      ea_d   = accept_ea;
      rd_d   = rd;
      ctrl_d = load_control;
    end
    if (state_q == WAIT && mem_rvalid) begin
      wb_data_d = align_data;
    end
  end

  // Next state; a flush after the grant must still swallow the outstanding response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
`ifdef LOAD_MISALIGN_TRAP_EN
          state_d = is_misaligned(load_control, accept_ea[1:0]) ? EXC : REQ;
`else
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_gnt)    state_d = flush ? DRAIN : WAIT;
        else if (flush) state_d = IDLE;
      end
      WAIT: begin
        if (mem_rvalid) state_d = flush ? IDLE : WB;
        else if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (mem_rvalid) state_d = IDLE;
      end
      WB:      state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; data buses are zero outside the state that owns them.
  always_comb begin
    ld_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    mem_req  = (state_q == REQ);
    mem_addr = (state_q == REQ) ? {ea_q[XLEN-1:2], 2'b00} : '0;
    wb_valid = (state_q == WB) && !(ZERO_RD_SUPPRESS && (rd_q == 5'd0));
    wb_rd    = (state_q == WB) ? rd_q : 5'd0;
    wb_data  = (state_q == WB) ? wb_data_q : '0;
`ifdef LOAD_MISALIGN_TRAP_EN
    misalign_exc = (state_q == EXC);
    exc_addr     = (state_q == EXC) ? ea_q : '0;
`else
    misalign_exc = 1'b0;
    exc_addr     = '0;
`endif
  end

endmodule
